// File: rtl/snd_pkg.sv
// Shared constants, sample type and prescaler helper for the sound sample FIFO.
package snd_pkg;

  localparam logic [1:0] RATE_6K25 = 2'b00;
  localparam logic [1:0] RATE_12K5 = 2'b01;
  localparam logic [1:0] RATE_25K  = 2'b10;
  localparam logic [1:0] RATE_50K  = 2'b11;

  // Prescaler width; covers DIV_50K << 3 for the default 640-cycle divider.
  localparam int unsigned PRESC_W = 16;

  typedef logic signed [7:0] sample_t;

  // Sample period in clk32 cycles for a rate code; each step down halves the rate.
  function automatic logic [PRESC_W-1:0] period(input logic [1:0] rate_i,
                                                input int unsigned div_50k);
    return PRESC_W'(div_50k << (2'd3 - rate_i));
  endfunction

endpackage

// File: rtl/snd_word_fifo.sv
// DEPTH x 16 synchronous word FIFO; push and pop may coincide even when full.
module snd_word_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk32,
  input  logic          por,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [15:0]   din,
  output logic [15:0]   dout,
  output logic [CW-1:0] count
);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk32) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; flush empties the queue like reset.
  always_ff @(posedge clk32) begin
    if (por || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/snd_sample_fifo.sv
// Sound DMA consumer: requests/buffers words and plays them out as L/R samples.
module snd_sample_fifo import snd_pkg::*; #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DIV_50K = 640
) (
  input  logic        clk32,
  input  logic        por,
  input  logic        sndon,
  input  logic        mono,
  input  logic [1:0]  rate,
  input  logic        sload,
  input  logic [15:0] din,
  output logic        sreq,
  output sample_t     left,
  output sample_t     right,
  output logic        strobe,
  output logic        underrun,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] period_q, period_d;
  logic               phase_q, phase_d;
  logic               sndon_q;
  logic               sreq_q, sreq_d;
  sample_t            left_q, left_d;
  sample_t            right_q, right_d;
  logic               strobe_q, strobe_d;
  logic               underrun_q, underrun_d;
  logic               overflow_q, overflow_d;

  logic               tick;
  logic               push;
  logic               pop;
  logic               flush;
  logic [15:0]        head;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;

  assign flush = ~sndon;

  snd_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk32 (clk32),
    .por   (por),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (count)
  );

  // Prescaler, playback phase, load/pop arbitration and output next-state.
  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    phase_d    = phase_q;
    sreq_d     = 1'b0;
    left_d     = left_q;
    right_d    = right_q;
    strobe_d   = 1'b0;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    tick       = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    count_nxt  = '0;

    if (!sndon) begin
      // Idle: hold prescaler at 0 and track the programmed rate for the next start.
      cnt_d    = '0;
      period_d = period(rate, DIV_50K);
      phase_d  = 1'b0;
      left_d   = '0;
      right_d  = '0;
    end else begin
      if (!sndon_q) begin
        underrun_d = 1'b0;
        overflow_d = 1'b0;
      end

      tick = (cnt_q == period_q - PRESC_W'(1));
      if (tick) begin
        cnt_d    = '0;
        period_d = period(rate, DIV_50K);
      end else begin
        cnt_d = cnt_q + PRESC_W'(1);
      end

      if (tick) begin
        if (count != '0) begin
          strobe_d = 1'b1;
          if (!mono) begin
            // Stereo also recovers from a half-played mono word by playing it as a pair.
            left_d  = sample_t'(head[15:8]);
            right_d = sample_t'(head[7:0]);
            pop     = 1'b1;
            phase_d = 1'b0;
          end else if (!phase_q) begin
            left_d  = sample_t'(head[15:8]);
            right_d = sample_t'(head[15:8]);
            phase_d = 1'b1;
          end else begin
            left_d  = sample_t'(head[7:0]);
            right_d = sample_t'(head[7:0]);
            pop     = 1'b1;
            phase_d = 1'b0;
          end
        end else begin
          underrun_d = 1'b1;
        end
      end

      // A same-cycle pop frees a slot, so a load into a full FIFO is accepted.
      if (sload) begin
        if ((count != CW'(DEPTH)) || pop) begin
          push = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end

      // One slot stays free for the word already in flight.
      count_nxt = count + CW'(push) - CW'(pop);
      sreq_d    = (count_nxt < CW'(DEPTH - 1));
    end
  end

  // State and output registers; por overrides everything.
  always_ff @(posedge clk32) begin
    if (por) begin
      cnt_q      <= '0;
      period_q   <= period(rate, DIV_50K);
      phase_q    <= 1'b0;
      sndon_q    <= 1'b0;
      sreq_q     <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      phase_q    <= phase_d;
      sndon_q    <= sndon;
      sreq_q     <= sreq_d;
      left_q     <= left_d;
      right_q    <= right_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign sreq     = sreq_q;
  assign left     = left_q;
  assign right    = right_q;
  assign strobe   = strobe_q;
  assign underrun = underrun_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_snd_sample_fifo.sv
// Directed bench for snd_sample_fifo (DEPTH=4, DIV_50K=640).
module tb_snd_sample_fifo;

  localparam int LIMIT = 12000;

  logic        clk32 = 1'b0;
  logic        por = 1'b1;
  logic        sndon = 1'b0;
  logic        mono = 1'b0;
  logic [1:0]  rate = 2'b11;
  logic        sload = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        sreq;
  logic [7:0]  left;
  logic [7:0]  right;
  logic        strobe;
  logic        underrun;
  logic        overflow;

  int ntests = 0;
  int nfail  = 0;
  int sreq_bad = 0;

  snd_sample_fifo #(.DEPTH(4), .DIV_50K(640)) dut (
    .clk32    (clk32),
    .por      (por),
    .sndon    (sndon),
    .mono     (mono),
    .rate     (rate),
    .sload    (sload),
    .din      (din),
    .sreq     (sreq),
    .left     (left),
    .right    (right),
    .strobe   (strobe),
    .underrun (underrun),
    .overflow (overflow)
  );

  always #5 clk32 = ~clk32;

  // sreq must never be high while the FIFO holds DEPTH-1 words.
  always @(negedge clk32) begin
    if (sreq === 1'b1 && dut.u_fifo.count === 3'd3) sreq_bad++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk32);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges until strobe shows (at least one), bounded by LIMIT.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!strobe && n < LIMIT);
  endtask

  initial begin
    int n;
    logic [7:0] exp_hi [4];
    logic       saw;
    exp_hi[0] = 8'h22; exp_hi[1] = 8'h33; exp_hi[2] = 8'h44; exp_hi[3] = 8'h66;

    // Reset and idle
    cyc(3);
    por = 1'b0;
    check("rst_sreq", 32'(sreq), 32'h0);
    check("rst_left", 32'(left), 32'h0);
    check("rst_right", 32'(right), 32'h0);
    check("rst_strobe", 32'(strobe), 32'h0);
    check("rst_flags", {30'h0, underrun, overflow}, 32'h0);
    saw = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cyc(1);
      if (strobe || sreq) saw = 1'b1;
    end
    check("idle_quiet", 32'(saw), 32'h0);

    // Stereo 50 kHz
    rate = 2'b11; mono = 1'b0; sndon = 1'b1;
    cyc(1);
    check("st_sreq_on", 32'(sreq), 32'h1);
    sload = 1'b1; din = 16'h7F80; cyc(1);
    din = 16'h0102; cyc(1);
    din = 16'h1234; cyc(1);
    sload = 1'b0;
    check("st_count3", 32'(dut.u_fifo.count), 32'h3);
    check("st_sreq_off", 32'(sreq), 32'h0);
    wait_strobe(n);
    check("st_first_lat", 32'(n), 32'(640 - 4));
    check("st_left0", 32'(left), 32'h7F);
    check("st_right0", 32'(right), 32'h80);
    check("st_sreq_again", 32'(sreq), 32'h1);
    cyc(1);
    check("st_strobe_1cyc", 32'(strobe), 32'h0);
    wait_strobe(n);
    check("st_period", 32'(n), 32'(640 - 1));
    check("st_left1", 32'(left), 32'h01);
    check("st_right1", 32'(right), 32'h02);
    wait_strobe(n);
    check("st_left2", 32'(left), 32'h12);
    check("st_right2", 32'(right), 32'h34);

    // Underrun on an empty FIFO: values hold, no strobe
    cyc(639);
    check("ur_before", 32'(underrun), 32'h0);
    cyc(1);
    check("ur_set", 32'(underrun), 32'h1);
    check("ur_nostrobe", 32'(strobe), 32'h0);
    check("ur_hold", {24'h0, left}, 32'h12);
    sndon = 1'b0; rate = 2'b00; mono = 1'b1;
    cyc(1);
    check("off_left", 32'(left), 32'h0);
    check("off_ur_sticky", 32'(underrun), 32'h1);

    // Mono 6.25 kHz
    sndon = 1'b1;
    cyc(1);
    check("mo_ur_clear", 32'(underrun), 32'h0);
    sload = 1'b1; din = 16'hA55A; cyc(1);
    sload = 1'b0;
    wait_strobe(n);
    check("mo_lat", 32'(n), 32'(5120 - 2));
    check("mo_lr_hi", {16'h0, left, right}, 32'hA5A5);
    check("mo_nopop", 32'(dut.u_fifo.count), 32'h1);
    wait_strobe(n);
    check("mo_period", 32'(n), 32'h1400);
    check("mo_lr_lo", {16'h0, left, right}, 32'h5A5A);
    check("mo_pop", 32'(dut.u_fifo.count), 32'h0);

    // Full, overflow and simultaneous load/pop
    sndon = 1'b0; rate = 2'b11; mono = 1'b0;
    cyc(1);
    sndon = 1'b1; sload = 1'b1;
    din = 16'h1111; cyc(1);
    din = 16'h2222; cyc(1);
    din = 16'h3333; cyc(1);
    din = 16'h4444; cyc(1);
    check("full_noovf", 32'(overflow), 32'h0);
    din = 16'h5555; cyc(1);
    sload = 1'b0;
    check("full_ovf", 32'(overflow), 32'h1);
    check("full_count", 32'(dut.u_fifo.count), 32'h4);
    cyc(634);
    sload = 1'b1; din = 16'h6666; cyc(1);
    sload = 1'b0;
    check("sim_strobe", 32'(strobe), 32'h1);
    check("sim_left", 32'(left), 32'h11);
    check("sim_count", 32'(dut.u_fifo.count), 32'h4);
    check("sim_ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_strobe(n);
      check("drain_left", 32'(left), 32'(exp_hi[i]));
    end

    // Mid-stream abort and restart
    sload = 1'b1;
    din = 16'hAAAA; cyc(1);
    din = 16'hBBBB; cyc(1);
    din = 16'hCCCC; cyc(1);
    sload = 1'b0;
    sndon = 1'b0;
    cyc(1);
    check("ab_count", 32'(dut.u_fifo.count), 32'h0);
    check("ab_sreq", 32'(sreq), 32'h0);
    check("ab_lr", {16'h0, left, right}, 32'h0);
    check("ab_ovf_kept", 32'(overflow), 32'h1);
    sload = 1'b1; din = 16'hDEAD; cyc(1);
    sload = 1'b0;
    check("off_load_ign", 32'(dut.u_fifo.count), 32'h0);
    sndon = 1'b1;
    cyc(1);
    check("re_flags", {30'h0, underrun, overflow}, 32'h0);
    sload = 1'b1; din = 16'h0F0E; cyc(1);
    sload = 1'b0;
    wait_strobe(n);
    check("re_lat", 32'(n), 32'(640 - 2));
    check("re_lr", {16'h0, left, right}, 32'h0F0E);

    // por mid-operation wins over a load
    sload = 1'b1; din = 16'h1357; cyc(1);
    por = 1'b1;
    cyc(1);
    check("por_count", 32'(dut.u_fifo.count), 32'h0);
    check("por_lr", {16'h0, left, right}, 32'h0);
    check("por_sreq", 32'(sreq), 32'h0);
    por = 1'b0; sload = 1'b0; sndon = 1'b0;
    cyc(2);

    check("sreq_rule", 32'(sreq_bad), 32'h0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/snd_sample_fifo.md
Name: snd_sample_fifo

Overview:
- Consumer end of the sound DMA handshake.
- Requests words from the memory controller via sreq and accepts each word fetched on a load strobe.
- Buffers the words and plays them out as signed 8-bit left/right samples at the programmed sample rate.
- Sits between the MCU sound-DMA control (sreq/sload) and the audio DAC/mixer path.

Parameters:
- DEPTH, 4, FIFO depth in 16-bit words (power of two, ≥2).
- DIV_50K, 640, clk32 cycles per sample period at the 50 kHz rate.

Ports:
- clk32  in  1  system clock, all logic on rising edge
- por  in  1  reset, synchronous, active-high
- sndon  in  1  playback enable
- mono  in  1  1 = mono (each byte one sample), 0 = stereo (high byte left, low byte right)
- rate  in  2  00=6.25 kHz, 01=12.5 kHz, 10=25 kHz, 11=50 kHz
- sload  in  1  one-cycle strobe: capture din into FIFO
- din  in  16  DMA data word
- sreq  out  1  request next word
- left  out  8  current left sample, signed
- right  out  8  current right sample, signed
- strobe  out  1  one-cycle pulse when left/right update
- underrun  out  1  sticky: sample period hit an empty FIFO
- overflow  out  1  sticky: sload while full

Behaviour:
- Reset (por=1) values:
  - FIFO empty; prescaler 0; byte phase 0.
  - sreq=0, left=0, right=0, strobe=0, underrun=0, overflow=0.
- Prescaler:
  - Counts 0..(DIV_50K<<(3-rate))-1.
  - Issues an internal tick on the last count, then wraps to 0.
  - A rate change takes effect at the next wrap.
  - Held at 0 while sndon=0.
  - After sndon rises, the first tick occurs DIV_50K<<(3-rate) cycles later.
- sreq:
  - Registered: sreq = sndon & (count < DEPTH-1).
  - Keeps one slot free for a word already in flight.
  - Deasserts the cycle after the load that makes count = DEPTH-1.
- Load:
  - On sload with count < DEPTH: write din, count += 1.
  - On sload with count = DEPTH: drop the word and set overflow.
- Tick, stereo (mono=0), count > 0:
  - left <= head[15:8], right <= head[7:0].
  - Pop the head; count -= 1.
  - strobe=1 for one cycle, the cycle after the tick.
- Tick, mono (mono=1), count > 0:
  - Phase 0: left = right = head[15:8]; phase becomes 1; no pop.
  - Phase 1: left = right = head[7:0]; pop; phase becomes 0.
  - strobe as for stereo.
- Tick with count = 0:
  - left/right hold their values; no strobe; underrun set; phase unchanged.
- Simultaneous sload and popping tick:
  - Both occur; count unchanged.
  - Legal even when full; the pop frees the slot in the same cycle, so no overflow.
- Wrap-around:
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- mono changed mid-stream:
  - Takes effect at the next tick.
  - Switching to stereo with phase=1 resets phase to 0 without popping.
  - The half-used word is then played as a stereo pair.
- sndon low:
  - Synchronous flush: FIFO empty, phase 0, prescaler 0, sreq=0, left=right=0.
  - Sticky flags are kept.
  - An sload while sndon=0 is ignored and does not set overflow.
- Sticky flags:
  - Cleared only by por.
  - Or by a rising sndon edge, i.e. when starting a new playback.
- por mid-operation:
  - Aborts everything next cycle; all state returns to reset values.
  - por has priority over sload and tick.

Decomposition:
- Package snd_pkg:
  - Rate encoding constants RATE_6K25..RATE_50K.
  - Function period(rate, DIV_50K).
  - Sample byte type (signed 8-bit).
- Sub-module snd_word_fifo:
  - Parameterised DEPTH x 16 synchronous FIFO.
  - Interface: push/pop/din/dout/count; por and flush clear it.
  - Pop-and-push in the same cycle supported when full.
- Top level holds the prescaler, phase, sreq and output registers.

Test Plan:
- Reset/idle: por 3 cycles, sndon=0 -> sreq=0, left=right=0, no strobe for 2000 cycles.
- Stereo 50 kHz:
  - Stimulus: sndon=1, rate=11, mono=0, feed 0x7F80, 0x0102 on each sreq.
  - Response: strobe at cycle 641 after sndon with left=0x7F, right=0x80; next strobe 640 cycles later with 0x01/0x02.
  - sreq never asserted while count = DEPTH-1.
- Mono 6.25 kHz, word 0xA55A:
  - Response: strobes 5120 cycles apart giving L=R=0xA5, then L=R=0x5A.
  - Pop only after the second strobe.
- Underrun: sndon=1, never drive sload -> at the first tick underrun=1, no strobe, outputs stay 0.
- Full/simultaneous:
  - Fill to DEPTH with sload ignoring sreq, then one extra sload -> overflow=1, count stays 4.
  - Then sload coinciding with a tick -> count stays 4, overflow unchanged.
- Mid-stream abort: sndon low with 3 words queued -> next cycle count=0, sreq=0, left=right=0; re-enable -> flags cleared, first tick after a full period.
